if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response capture into a
// small prefetch buffer, and redirect handling that drops responses still in flight.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr_out,
    output logic [31:0] fetch_instr_out
);

    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INIT   = RESET_PC & WORD_MASK;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [CW:0] CREDIT    = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] out_cnt_q;
    logic [CW-1:0] out_cnt_next;
    logic [CW-1:0] disc_cnt_q;
    logic [CW-1:0] occ_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [31:0]   buf_addr  [DEPTH];
    logic [31:0]   buf_instr [DEPTH];

    logic grant;
    logic rsp_live;
    logic drop;
    logic push;
    logic pop;

    // Credit counts buffered entries plus every grant still owed a response,
    // including ones that will be discarded, so a push can never find the buffer full.
    assign imem_req  = rst_n && !redirect_valid &&
                       (({1'b0, occ_q} + {1'b0, out_cnt_q}) < CREDIT);
    assign imem_addr = pc_q;

    assign grant    = imem_req && imem_gnt;
    // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
    assign rsp_live = imem_rvalid && (out_cnt_q != '0);
    assign drop     = rsp_live && (disc_cnt_q != '0);
    assign push     = rsp_live && (disc_cnt_q == '0) && !redirect_valid;
    assign pop      = fetch_valid && !stall && !redirect_valid;

    always_comb begin
        out_cnt_next = out_cnt_q;
        if (grant && !rsp_live) begin
            out_cnt_next = out_cnt_q + CW'(1);
        end else if (!grant && rsp_live) begin
            out_cnt_next = out_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_INIT;
            resp_pc_q  <= PC_INIT;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            out_cnt_q <= out_cnt_next;
            if (redirect_valid) begin
                pc_q       <= redirect_pc & WORD_MASK;
                resp_pc_q  <= redirect_pc & WORD_MASK;
                disc_cnt_q <= out_cnt_next;
                occ_q      <= '0;
                head_q     <= '0;
                tail_q     <= '0;
            end else begin
                if (grant) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (drop) begin
                    disc_cnt_q <= disc_cnt_q - CW'(1);
                end
                // Responses are in order, so the next kept response belongs to resp_pc_q.
                if (push) begin
                    tail_q    <= tail_q + PW'(1);
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (pop) begin
                    head_q <= head_q + PW'(1);
                end
                if (push && !pop) begin
                    occ_q <= occ_q + CW'(1);
                end else if (pop && !push) begin
                    occ_q <= occ_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail_q]  <= resp_pc_q;
            buf_instr[tail_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (occ_q != FULL);
        end
    end

    assign fetch_valid     = (occ_q != '0);
    assign fetch_addr_out  = fetch_valid ? buf_addr[head_q]  : 32'h0;
    assign fetch_instr_out = fetch_valid ? buf_instr[head_q] : NOP;

endmodule
